// File: rtl/add_share_pkg.sv
// Shared types and constants for the add_share_arb adder-sharing slice.
package add_share_pkg;

  localparam int NREQ_MAX = 4;
  localparam int DW       = 16;

  function automatic int idw(input int n);
    for (int w = 1; w < 8; w++) begin
      if ((1 << w) >= n) return w;
    end
    return 8;
  endfunction

  localparam int ID_MAXW = idw(NREQ_MAX);

  typedef struct packed {
    logic [ID_MAXW-1:0] id;
    logic [DW-1:0]      sum;
    logic               cout;
    logic               ovf;
    logic               zero;
  } rsp_t;

endpackage

// File: rtl/add_share_arb_cla.sv
// 16-bit adder built from four 4-bit carry-lookahead groups.
module cla_16bit (
  input  logic [15:0] a,
  input  logic [15:0] b,
  input  logic        cin,
  output logic [15:0] sum,
  output logic        cout
);

  logic [15:0] g, p, c;
  logic [3:0]  bg, bp;
  logic [4:0]  cb;

  assign g = a & b;
  assign p = a ^ b;

  always_comb begin
    bg = '0;
    bp = '0;
    cb = '0;
    c  = '0;
    cb[0] = cin;
    for (int k = 0; k < 4; k++) begin
      bp[k] = &p[4*k +: 4];
      bg[k] = g[4*k+3] | (p[4*k+3] & g[4*k+2]) | (p[4*k+3] & p[4*k+2] & g[4*k+1])
            | (p[4*k+3] & p[4*k+2] & p[4*k+1] & g[4*k]);
      cb[k+1] = bg[k] | (bp[k] & cb[k]);
    end
    // group carries come from the lookahead tree, interior bits ripple within the group
    for (int i = 0; i < 16; i++) begin
      if (i % 4 == 0) c[i] = cb[i/4];
      else            c[i] = g[i-1] | (p[i-1] & c[i-1]);
    end
  end

  assign sum  = p ^ c;
  assign cout = cb[4];

endmodule

// File: rtl/add_share_arb_rr_arb.sv
// Combinational round-robin picker: first set request after index `last`, wrapping.
module rr_arb
  import add_share_pkg::*;
#(
  parameter int N  = 4,
  parameter int IW = idw(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] last,
  input  logic          en,
  output logic [N-1:0]  gnt,
  output logic [IW-1:0] gnt_idx
);

  logic found;

  always_comb begin
    found   = 1'b0;
    gnt_idx = '0;
    gnt     = '0;
    for (int k = 1; k <= N; k++) begin
      if (!found && req[(int'(last) + k) % N]) begin
        found   = 1'b1;
        gnt_idx = IW'((int'(last) + k) % N);
      end
    end
    if (found && en) gnt[gnt_idx] = 1'b1;
  end

endmodule

// File: rtl/add_share_arb.sv
// Shares one cla_16bit among NREQ requesters; one-deep tagged response slot.
module add_share_arb
  import add_share_pkg::*;
#(
  parameter int NREQ = 4,
  parameter int IDW  = idw(NREQ)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [NREQ-1:0]    req_valid,
  output logic [NREQ-1:0]    req_ready,
  input  logic [NREQ*DW-1:0] req_a,
  input  logic [NREQ*DW-1:0] req_b,
  input  logic [NREQ-1:0]    req_sub,
  output logic               rsp_valid,
  input  logic               rsp_ready,
  output logic [IDW-1:0]     rsp_id,
  output logic [DW-1:0]      rsp_sum,
  output logic               rsp_cout,
  output logic               rsp_ovf,
  output logic               rsp_zero
);

  logic [IDW-1:0] last, gnt_idx;
  logic [NREQ-1:0] gnt;
  logic           can_accept, xfer, sub;
  logic [DW-1:0]  op_a, op_b, sum;
  logic           cout, ovf;
  rsp_t           slot;

  assign can_accept = !rsp_valid || rsp_ready;

  // rst_n in the enable keeps req_ready low for the whole reset window
  rr_arb #(.N(NREQ), .IW(IDW)) u_arb (
    .req     (req_valid),
    .last    (last),
    .en      (can_accept && rst_n),
    .gnt     (gnt),
    .gnt_idx (gnt_idx)
  );

  assign req_ready = gnt;
  assign xfer      = |gnt;

  assign sub  = req_sub[gnt_idx];
  assign op_a = req_a[int'(gnt_idx)*DW +: DW];
  assign op_b = req_b[int'(gnt_idx)*DW +: DW] ^ {DW{sub}};

  cla_16bit u_cla (
    .a    (op_a),
    .b    (op_b),
    .cin  (sub),
    .sum  (sum),
    .cout (cout)
  );

  assign ovf = (op_a[DW-1] == op_b[DW-1]) && (sum[DW-1] != op_a[DW-1]);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_valid <= 1'b0;
      slot      <= '0;
      last      <= IDW'(NREQ-1);
    end else if (xfer) begin
      rsp_valid <= 1'b1;
      slot      <= '{id: ID_MAXW'(gnt_idx), sum: sum, cout: cout, ovf: ovf, zero: (sum == '0)};
      last      <= gnt_idx;
    end else if (rsp_ready) begin
      rsp_valid <= 1'b0;
    end
  end

  assign rsp_id   = slot.id[IDW-1:0];
  assign rsp_sum  = slot.sum;
  assign rsp_cout = slot.cout;
  assign rsp_ovf  = slot.ovf;
  assign rsp_zero = slot.zero;

endmodule

// File: tb/tb_add_share_arb.sv
// Scoreboard bench for add_share_arb: stimulus pushes hand-computed responses, monitor pops.
module tb_add_share_arb;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [3:0]  req_valid, req_ready, req_sub;
  logic [63:0] req_a, req_b;
  logic        rsp_valid, rsp_ready;
  logic [1:0]  rsp_id;
  logic [15:0] rsp_sum;
  logic        rsp_cout, rsp_ovf, rsp_zero;

  int total = 0;
  int bad   = 0;
  logic [20:0] exp_q[$];

  always #5 clk = ~clk;

  add_share_arb #(.NREQ(4), .IDW(2)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_a     (req_a),
    .req_b     (req_b),
    .req_sub   (req_sub),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_id    (rsp_id),
    .rsp_sum   (rsp_sum),
    .rsp_cout  (rsp_cout),
    .rsp_ovf   (rsp_ovf),
    .rsp_zero  (rsp_zero)
  );

  function automatic logic [20:0] er(input logic [1:0] id, input logic [15:0] s,
                                     input logic c, input logic o, input logic z);
    return {id, s, c, o, z};
  endfunction

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  task automatic set_op(input int i, input logic [15:0] a, input logic [15:0] b, input logic s);
    req_a[16*i +: 16] = a;
    req_b[16*i +: 16] = b;
    req_sub[i]        = s;
  endtask

  // settle, check the grant, queue the expected response if a transfer is due, advance a cycle
  task automatic step(input string nm, input logic [3:0] want_gnt, input logic [20:0] exp);
    #1;
    check(nm, {28'b0, req_ready}, {28'b0, want_gnt});
    if (want_gnt != 4'b0) exp_q.push_back(exp);
    @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    if (rst_n && rsp_valid) begin
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL rsp_unexpected: got id=%0d sum=%h want no response", rsp_id, rsp_sum);
      end else begin
        check("rsp", {11'b0, rsp_id, rsp_sum, rsp_cout, rsp_ovf, rsp_zero}, {11'b0, exp_q[0]});
        if (rsp_ready) void'(exp_q.pop_front());
      end
    end
  end

  initial begin
    rsp_ready = 1'b1;
    req_valid = 4'hf;
    req_a = '0;
    req_b = '0;
    req_sub = '0;
    set_op(0, 16'h1000, 16'h0001, 1'b0);
    set_op(1, 16'h2000, 16'h0001, 1'b0);
    set_op(2, 16'h3000, 16'h0001, 1'b0);
    set_op(3, 16'h4000, 16'h0001, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    check("rst_valid", {31'b0, rsp_valid}, 32'h0);
    check("rst_ready", {28'b0, req_ready}, 32'h0);
    check("rst_fields", {11'b0, rsp_id, rsp_sum, rsp_cout, rsp_ovf, rsp_zero}, 32'h0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    step("rr0", 4'b0001, er(2'd0, 16'h1001, 1'b0, 1'b0, 1'b0));
    step("rr1", 4'b0010, er(2'd1, 16'h2001, 1'b0, 1'b0, 1'b0));
    step("rr2", 4'b0100, er(2'd2, 16'h3001, 1'b0, 1'b0, 1'b0));
    step("rr3", 4'b1000, er(2'd3, 16'h4001, 1'b0, 1'b0, 1'b0));
    step("rr0b", 4'b0001, er(2'd0, 16'h1001, 1'b0, 1'b0, 1'b0));
    req_valid = 4'b0000;
    step("idle", 4'b0000, '0);
    check("drain", {31'b0, rsp_valid}, 32'h0);

    set_op(2, 16'h7fff, 16'h0001, 1'b0);
    req_valid = 4'b0100;
    step("add_ovf", 4'b0100, er(2'd2, 16'h8000, 1'b0, 1'b1, 1'b0));
    set_op(1, 16'h0005, 16'h0005, 1'b1);
    req_valid = 4'b0010;
    step("sub_eq", 4'b0010, er(2'd1, 16'h0000, 1'b1, 1'b0, 1'b1));
    set_op(1, 16'h0003, 16'h0005, 1'b1);
    step("sub_neg", 4'b0010, er(2'd1, 16'hfffe, 1'b0, 1'b0, 1'b0));
    set_op(3, 16'h8000, 16'h0001, 1'b1);
    req_valid = 4'b1000;
    step("sub_ovf", 4'b1000, er(2'd3, 16'h7fff, 1'b1, 1'b1, 1'b0));
    set_op(0, 16'hffff, 16'h0001, 1'b0);
    req_valid = 4'b0001;
    step("add_carry", 4'b0001, er(2'd0, 16'h0000, 1'b1, 1'b0, 1'b1));

    req_valid = 4'b0000;
    step("drain2", 4'b0000, '0);
    rsp_ready = 1'b0;
    set_op(0, 16'h1234, 16'h1111, 1'b0);
    req_valid = 4'b0001;
    step("bp_fill", 4'b0001, er(2'd0, 16'h2345, 1'b0, 1'b0, 1'b0));
    set_op(1, 16'h0100, 16'h0001, 1'b1);
    req_valid = 4'b0011;
    repeat (3) step("bp_hold", 4'b0000, '0);
    rsp_ready = 1'b1;
    step("bp_release", 4'b0010, er(2'd1, 16'h00ff, 1'b1, 1'b0, 1'b0));
    rsp_ready = 1'b0;
    req_valid = 4'b0000;
    step("bp_after", 4'b0000, '0);
    check("bp_full", {31'b0, rsp_valid}, 32'h1);

    req_valid = 4'hf;
    #3;
    rst_n = 1'b0;
    #1;
    check("midrst_valid", {31'b0, rsp_valid}, 32'h0);
    check("midrst_ready", {28'b0, req_ready}, 32'h0);
    check("midrst_fields", {11'b0, rsp_id, rsp_sum, rsp_cout, rsp_ovf, rsp_zero}, 32'h0);
    exp_q.delete();
    @(posedge clk);
    #1;
    rsp_ready = 1'b1;
    rst_n = 1'b1;

    set_op(0, 16'h0001, 16'h0001, 1'b0);
    set_op(3, 16'h0003, 16'h0003, 1'b0);
    req_valid = 4'b1001;
    step("wrap0", 4'b0001, er(2'd0, 16'h0002, 1'b0, 1'b0, 1'b0));
    step("wrap3", 4'b1000, er(2'd3, 16'h0006, 1'b0, 1'b0, 1'b0));
    step("wrap0b", 4'b0001, er(2'd0, 16'h0002, 1'b0, 1'b0, 1'b0));
    step("wrap3b", 4'b1000, er(2'd3, 16'h0006, 1'b0, 1'b0, 1'b0));
    req_valid = 4'b0000;
    step("end_idle", 4'b0000, '0);
    step("end_idle2", 4'b0000, '0);
    check("end_valid", {31'b0, rsp_valid}, 32'h0);
    check("end_queue", exp_q.size(), 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/add_share_arb.md
# add_share_arb

Round-robin arbiter and sequencer that shares one `cla_16bit` adder among up to four requesters: the PC incrementer, the branch-target unit, the load/store address generator and the ALU. It grants at most one request per cycle and drives the adder with the granted operands. For subtracts it inverts `b` and forces carry-in. The result, carry and flags are registered into a single response slot that is tagged with the requester ID and held until consumed.

## Interface
Parameters:
- `NREQ`, 4: number of requesters (2..4).
- `IDW`, 2: width of requester ID, equal to clog2(`NREQ`).

Ports:
- `clk` in 1: system clock; all state updates on rising edge.
- `rst_n` in 1: reset. One clock; reset is asynchronous and active-low.
- `req_valid` in `NREQ`: per-requester request pending.
- `req_ready` out `NREQ`: one-hot grant; a request transfers when `req_valid[i]` and `req_ready[i]` are both high.
- `req_a` in `NREQ*16`: operand A, requester i at bits [16i+15:16i].
- `req_b` in `NREQ*16`: operand B, same packing as `req_a`.
- `req_sub` in `NREQ`: 1 selects A−B, 0 selects A+B.
- `rsp_valid` out 1: response slot full.
- `rsp_ready` in 1: consumer accepts the response.
- `rsp_id` out `IDW`: requester index of the held result.
- `rsp_sum` out 16: result.
- `rsp_cout` out 1: adder carry-out. For subtracts, 1 means no borrow.
- `rsp_ovf` out 1: signed overflow.
- `rsp_zero` out 1: `rsp_sum` equals 0.

## Operation
- Slot state is the `rsp_valid` bit: EMPTY (0) or FULL (1).
- `can_accept` = !`rsp_valid` | `rsp_ready`.
- Grant:
  - Search `req_valid` starting at index (`last` + 1) mod `NREQ` and wrapping; the first set bit wins.
  - `req_ready` is one-hot on the winner only when `can_accept`; otherwise it is all zero.
  - `req_ready` depends combinationally on `req_valid` and `rsp_ready`. A requester must not make `req_valid` depend on `req_ready`.
- Round-robin pointer `last` updates to the winner index only on a transfer. It holds when there is no transfer or under backpressure.
- Adder drive:
  - a = winner A; b = winner B XOR {16{sub}}; cin = sub.
  - The adder output is captured into the slot on transfer.
- Flags:
  - `rsp_ovf` = (a[15] == b'[15]) & (sum[15] != a[15]), where b' is the post-inversion operand.
  - `rsp_zero` = (sum == 0).
- Slot update per cycle:
  - Transfer: slot loads a new result, `rsp_valid` = 1. This applies even if the old result drains in the same cycle.
  - No transfer and `rsp_ready`: `rsp_valid` = 0.
  - Otherwise: hold.
- Response outputs are stable while `rsp_valid` & !`rsp_ready`.
- A requester keeps `req_valid` and its operands stable until granted. The arbiter does not buffer operands for ungranted requesters.
- Requesters with index ≥ `NREQ` do not exist. No X may propagate from unused packing.

## Timing
- Reset values: `rsp_valid` = 0, `rsp_id` = 0, `rsp_sum` = 0x0000, `rsp_cout` = 0, `rsp_ovf` = 0, `rsp_zero` = 0. `last` = `NREQ`−1, so requester 0 has top priority after reset.
- Latency: request transferred in cycle N gives `rsp_valid` = 1 with its result in cycle N+1.
- Throughput: 1 op/cycle when `rsp_ready` is held high.
- Simultaneous drain and grant: full throughput, no bubble.
- Fairness: a continuously valid requester is granted within `NREQ` transfers.
- Reset asserted mid-operation: the slot clears immediately (async), the held result is discarded, `last` returns to `NREQ`−1, and `req_ready` is all zero while `rst_n` = 0.
- All `req_valid` = 0: no grant, `last` holds, slot drains normally.

## Structure
- Shared package `add_share_pkg`: `NREQ_MAX` = 4, the `IDW` function, the 16-bit data-width constant, and the response struct typedef {id, sum, cout, ovf, zero}.
- Sub-module `rr_arb` (parameter N): inputs `req`, `last`, `en`; outputs one-hot `gnt` and `gnt_idx`. It is purely combinational.
- One `cla_16bit` instance in `add_share_arb`, fed from the winner mux. Slot and pointer registers are in `add_share_arb`.

## Test plan
- Reset: `rsp_valid` = 0, `req_ready` = 0000. After release, `req_valid` = 1111 grants requester 0 first, then 1, 2, 3, 0 on consecutive cycles with `rsp_ready` = 1.
- Add: req2 with a = 0x7FFF, b = 0x0001, sub = 0 gives next cycle `rsp_id` = 2, `rsp_sum` = 0x8000, `rsp_ovf` = 1, `rsp_cout` = 0.
- Subtract: req1 with a = 0x0005, b = 0x0005, sub = 1 gives `rsp_sum` = 0x0000, `rsp_zero` = 1, `rsp_cout` = 1, `rsp_ovf` = 0. Then a = 0x0003, b = 0x0005 gives 0xFFFE, `rsp_cout` = 0.
- Backpressure: hold `rsp_ready` = 0 with the slot full. `req_ready` stays 0000, the response holds all fields, and `last` is unchanged. Release for one cycle: drain and a new grant happen in the same cycle.
- Wrap/fairness: `req_valid` = 1001 continuously gives the grant sequence 0, 3, 0, 3.
- Reset mid-flight: with the slot full, assert `rst_n` low between clock edges. `rsp_valid` drops immediately with no clock edge required, and the next grant after release goes to requester 0.
